// File: rtl/ram512_loader.sv
// rtl/ram512_loader.sv - packs a byte stream into RAM words, then reads them back and verifies a checksum
module ram512_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL_HI = 3'd1;
  localparam logic [2:0] S_FILL_LO = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_VERIFY  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Counters are one bit wider than the address so a full 2**ADDR_W load is representable.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   idx;
  logic [7:0]        hi_byte;
  logic [DATA_W-1:0] wsum;
  logic [DATA_W-1:0] rsum;

  logic [ADDR_W:0]   idx_next;
  logic [DATA_W-1:0] rsum_next;

  assign idx_next   = idx + ONE;
  assign rsum_next  = rsum + ram_out;

  assign byte_ready = (state == S_FILL_HI) || (state == S_FILL_LO);
  assign ram_load   = (state == S_WRITE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      n_words     <= '0;
      idx         <= '0;
      hi_byte     <= '0;
      wsum        <= '0;
      rsum        <= '0;
      ram_data    <= '0;
      ram_address <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_words <= (length == '0) ? DEPTH : {1'b0, length};
            idx     <= '0;
            wsum    <= '0;
            rsum    <= '0;
            error   <= 1'b0;
            state   <= S_FILL_HI;
          end
        end
        S_FILL_HI: begin
          if (byte_valid) begin
            hi_byte <= byte_in;
            state   <= S_FILL_LO;
          end
        end
        S_FILL_LO: begin
          // Address and data change only here, so they stay put while the next word is filling.
          if (byte_valid) begin
            ram_data    <= {hi_byte, byte_in};
            ram_address <= idx[ADDR_W-1:0];
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          wsum <= wsum + ram_data;
          if (idx == n_words - ONE) begin
            idx         <= '0;
            ram_address <= '0;
            state       <= S_VERIFY;
          end else begin
            idx   <= idx_next;
            state <= S_FILL_HI;
          end
        end
        S_VERIFY: begin
          // idx counts verify cycles; ram_out reflects the address driven one cycle earlier.
          if (idx != '0) rsum <= rsum_next;
          if (idx_next < n_words) ram_address <= idx_next[ADDR_W-1:0];
          if (idx == n_words) begin
            error <= (rsum_next != wsum);
            state <= S_DONE;
          end else begin
            idx <= idx_next;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram512_loader.sv
// tb/tb_ram512_loader.sv - self-checking bench for ram512_loader with a registered-read RAM model
module tb_ram512_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  length;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] ram_data;
  logic        ram_load;
  logic [8:0]  ram_address;
  logic [15:0] ram_out;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  ram512_loader dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .ram_data(ram_data), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out), .busy(busy), .done(done), .error(error)
  );

  // RAM with 1-cycle registered read; corrupt forces address 1 to read back as zero.
  logic [15:0] mem [512];
  bit          corrupt = 1'b0;
  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_data;
    ram_out <= (corrupt && ram_address == 9'd1) ? 16'h0000 : mem[ram_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [24:0] wlog[$];
  int          done_seen = 0;
  int          done_cyc  = 0;
  logic        done_err  = 1'b0;
  always @(negedge clk) begin
    if (ram_load) wlog.push_back({ram_address, ram_data});
    if (done) begin
      done_seen = done_seen + 1;
      done_cyc  = cyc;
      done_err  = error;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] stim[$];

  task automatic fill_random(input int nbytes);
    stim.delete();
    for (int k = 0; k < nbytes; k++) stim.push_back(8'($urandom));
  endtask

  task automatic do_load(input string tag, input int nw, input int stall_pct,
                         input int gap_idx, input int gap_len, input bit bad1,
                         input bit poke_start, input bit chk_time);
    logic [15:0] w[$];
    logic [15:0] ws;
    logic [15:0] rs;
    logic        exp_err;
    int          wbase, dbase, t0, i, guard, gl, nbad, nw_seen;
    bit          v, take;

    // Reference: words are byte pairs high-then-low; verify reads back the same words.
    for (int k = 0; k < nw; k++) w.push_back({stim[2*k], stim[2*k+1]});
    ws = 16'h0;
    rs = 16'h0;
    for (int k = 0; k < nw; k++) begin
      ws = ws + w[k];
      rs = rs + ((bad1 && k == 1) ? 16'h0000 : w[k]);
    end
    exp_err = (rs != ws);

    corrupt = bad1;
    wbase = wlog.size();
    dbase = done_seen;

    @(negedge clk);
    start = 1'b1;
    length = 9'(nw);
    byte_valid = 1'b1;
    byte_in = 8'hEE;
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    check({tag, " error_cleared"}, 32'(error), 32'd0);

    i = 0;
    guard = 0;
    gl = gap_len;
    while (i < 2*nw && guard < 20000) begin
      v = ($urandom_range(99) >= 32'(stall_pct));
      if (i == gap_idx && gl > 0) begin
        v = 1'b0;
        gl--;
        check({tag, " gap_ready_held"}, 32'(byte_ready), 32'd1);
        check({tag, " gap_no_load"}, 32'(ram_load), 32'd0);
      end
      if (poke_start && i == 3) begin
        start = 1'b1;
        length = 9'd7;
      end else begin
        start = 1'b0;
      end
      byte_valid = v;
      byte_in = v ? stim[i] : 8'($urandom);
      take = v && byte_ready;
      @(negedge clk);
      if (take) i++;
      guard++;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    check({tag, " bytes_accepted"}, 32'(i), 32'(2*nw));

    guard = 0;
    while (done_seen == dbase && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check({tag, " done_pulses"}, 32'(done_seen - dbase), 32'd1);
    check({tag, " done_error"}, 32'(done_err), 32'(exp_err));
    check({tag, " error_held"}, 32'(error), 32'(exp_err));
    check({tag, " idle_after"}, 32'(busy), 32'd0);
    if (chk_time) check({tag, " done_latency"}, 32'(done_cyc - t0), 32'(4*nw + 1));

    nw_seen = wlog.size() - wbase;
    check({tag, " write_count"}, 32'(nw_seen), 32'(nw));
    nbad = 0;
    for (int k = 0; k < nw && k < nw_seen; k++)
      if (wlog[wbase + k] !== {9'(k), w[k]}) nbad++;
    check({tag, " write_content"}, 32'(nbad), 32'd0);
  endtask

  initial begin
    int wb;
    int nw;

    reset = 1'b1;
    start = 1'b0;
    length = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst byte_ready", 32'(byte_ready), 32'd0);
    check("rst ram_load", 32'(ram_load), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst ram_data", 32'(ram_data), 32'd0);
    check("rst ram_address", 32'(ram_address), 32'd0);
    reset = 1'b0;

    stim = {8'h12, 8'h34, 8'hAB, 8'hCD};
    do_load("t2_len2", 2, 0, -1, 0, 1'b0, 1'b0, 1'b1);

    stim.delete();
    repeat (1024) stim.push_back(8'hFF);
    do_load("t3_len512", 512, 0, -1, 0, 1'b0, 1'b0, 1'b1);

    fill_random(6);
    do_load("t4_gap", 3, 0, 1, 5, 1'b0, 1'b0, 1'b0);

    stim = {8'h12, 8'h34, 8'hAB, 8'hCD};
    do_load("t5_corrupt", 2, 0, -1, 0, 1'b1, 1'b0, 1'b1);
    fill_random(8);
    do_load("t5_recover", 4, 0, -1, 0, 1'b0, 1'b0, 1'b1);

    fill_random(10);
    do_load("t6_start_busy", 5, 20, -1, 0, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      nw = $urandom_range(24, 1);
      fill_random(2*nw);
      do_load("rand", nw, 30, -1, 0, 1'b0, 1'b0, 1'b0);
    end

    // Reset while a word is half assembled.
    @(negedge clk);
    start = 1'b1;
    length = 9'd4;
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    @(negedge clk);
    byte_valid = 1'b0;
    check("t6 in_fill_lo busy", 32'(busy), 32'd1);
    check("t6 in_fill_lo ready", 32'(byte_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6 reset busy", 32'(busy), 32'd0);
    check("t6 reset ready", 32'(byte_ready), 32'd0);
    wb = wlog.size();
    reset = 1'b0;
    byte_valid = 1'b1;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    check("t6 no_load_after_reset", 32'(wlog.size() - wb), 32'd0);
    check("t6 idle_after_reset", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
